// File: rtl/rotary_pkg.sv
// rotary_pkg: state encoding, per-direction line tables and timing constants shared by
// rotary_emulator and rotary_decoder.
package rotary_pkg;
  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4, GAP} rot_state_e;
  localparam int ROT_PHASE_CYC = 4000;
  localparam int ROT_DEBOUNCE_CYC = 40000;
  // {clk, dt} per phase, index 0 = PH1; each step flips exactly one line
  localparam logic [3:0][1:0] ROT_LVL_UP = {2'b11, 2'b01, 2'b00, 2'b10};
  localparam logic [3:0][1:0] ROT_LVL_DN = {2'b11, 2'b10, 2'b00, 2'b01};
  function automatic logic [1:0] rot_lines(input rot_state_e s, input logic dn);
    logic [1:0] idx;
    idx = 2'(s - PH1);
    return (s == IDLE || s == GAP) ? 2'b11 : dn ? ROT_LVL_DN[idx] : ROT_LVL_UP[idx];
  endfunction
endpackage

// File: rtl/step_accumulator.sv
// step_accumulator: saturating signed net-step counter; a request that would pass the limit
// is dropped and flagged for one cycle, while a detent dequeue is always honoured.
module step_accumulator #(
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    up_i,
  input  logic                    dn_i,
  input  logic                    deq_i,
  output logic signed [CNT_W-1:0] cnt_o,
  output logic                    pos_o,
  output logic                    neg_o,
  output logic                    overflow_o
);
  localparam int LIM = 2 ** (CNT_W - 1) - 1;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  int base, sum;
  always_comb begin
    base = int'(cnt_q) - (deq_i ? (neg_o ? -1 : pos_o ? 1 : 0) : 0);
    sum = base + int'(up_i) - int'(dn_i);
    ovf_d = sum > LIM || sum < -LIM;
    cnt_d = CNT_W'(ovf_d ? base : sum);
  end
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt_o = cnt_q;
  assign pos_o = cnt_q > 0;
  assign neg_o = cnt_q[CNT_W-1];
  assign overflow_o = ovf_q;
endmodule

// File: rtl/rotary_emulator.sv
// rotary_emulator: replays queued step requests as mechanical-encoder quadrature detents,
// each followed by an idle gap long enough for the decoder's debounce to settle.
module rotary_emulator import rotary_pkg::*; #(
  parameter int PHASE_CYCLES    = ROT_PHASE_CYC,
  parameter int GAP_CYCLES      = 48000,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = ROT_DEBOUNCE_CYC
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    step_up,
  input  logic                    step_dn,
  output logic                    rotary_clk,
  output logic                    rotary_dt,
  output logic                    busy,
  output logic                    step_done,
  output logic                    overflow,
  output logic signed [CNT_W-1:0] pending
);
  localparam int TMAX = PHASE_CYCLES > GAP_CYCLES ? PHASE_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PH_LOAD = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  if (GAP_CYCLES <= DEBOUNCE_CYCLES) begin : g_gap_chk
    $error("GAP_CYCLES must exceed the decoder debounce pause");
  end
  rot_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0] lines_q, lines_d;
  logic dn_q, dn_d, busy_q, busy_d, done_q, done_d;
  logic pos, neg, start;
  step_accumulator #(.CNT_W(CNT_W)) u_acc (
    .clk        (clk),
    .res_n      (res_n),
    .up_i       (step_up),
    .dn_i       (step_dn),
    .deq_i      (start),
    .cnt_o      (pending),
    .pos_o      (pos),
    .neg_o      (neg),
    .overflow_o (overflow)
  );
  assign start = state_q == IDLE && (pos || neg);
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      dn_q    <= 1'b0;
      lines_q <= 2'b11;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dn_q    <= dn_d;
      lines_q <= lines_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // one shared down-counter times every phase and the gap
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q - 1'b1;
    dn_d = start ? neg : dn_q;
    if (state_q == IDLE) begin
      state_d = start ? PH1 : IDLE;
      tmr_d = start ? PH_LOAD : '0;
    end else if (tmr_q == '0) begin
      state_d = state_q == PH1 ? PH2 : state_q == PH2 ? PH3 : state_q == PH3 ? PH4 :
                state_q == PH4 ? GAP : IDLE;
      tmr_d = state_q == PH4 ? GAP_LOAD : state_q == GAP ? '0 : PH_LOAD;
    end
  end
  always_comb begin
    lines_d = rot_lines(state_d, dn_d);
    busy_d = state_d != IDLE;
    done_d = state_q == PH4 && state_d == GAP;
  end
  assign rotary_clk = lines_q[1];
  assign rotary_dt = lines_q[0];
  assign busy = busy_q;
  assign step_done = done_q;
endmodule

// File: tb/tb_rotary_emulator.sv
// tb_rotary_emulator: randomized scoreboard bench; a detent-timeline model predicts every
// detent start, direction and dropped request, and monitors check the DUT against it.
module tb_rotary_emulator;
  localparam int P = 4, G = 10, W = 4, LIM = 7, DET = 4 * P + G;
  typedef struct {int start; int dir;} det_t;
  logic clk = 1'b0, res_n = 1'b0, step_up = 1'b0, step_dn = 1'b0;
  logic rotary_clk, rotary_dt, busy, step_done, overflow;
  logic signed [W-1:0] pending;
  det_t exp_q[$];
  det_t m_e;
  int ovf_q[$];
  int cyc = 0, pend = 0, free_at = 0, m_dq, m_base, m_sum;
  int compared = 0, mismatched = 0;
  int det_cnt = 0, ovf_cnt = 0, up_seen = 0, dn_seen = 0, up_exp = 0, dn_exp = 0;
  bit mon_en = 1'b0, armed = 1'b0;
  logic prev_clk = 1'b1;

  rotary_emulator #(.PHASE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(W), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .res_n(res_n), .step_up(step_up), .step_dn(step_dn),
    .rotary_clk(rotary_clk), .rotary_dt(rotary_dt), .busy(busy),
    .step_done(step_done), .overflow(overflow), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // {clk,dt} as 2-bit values: up 10,00,01,11 ; down 01,00,10,11
  function automatic int lvl(input int dir, input int ph);
    int up_seq[4] = '{2, 0, 1, 3};
    int dn_seq[4] = '{1, 0, 2, 3};
    return dir > 0 ? up_seq[ph] : dn_seq[ph];
  endfunction

  // reference: net-step arithmetic plus a timeline of when the engine is free to start
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!res_n) begin
      pend = 0;
      free_at = cyc + 1;
      exp_q.delete();
    end else begin
      m_dq = 0;
      if (cyc >= free_at && pend != 0) begin
        m_dq = pend > 0 ? 1 : -1;
        exp_q.push_back('{cyc, m_dq});
        if (m_dq > 0) up_exp++; else dn_exp++;
        free_at = cyc + DET + 1;
      end
      m_base = pend - m_dq;
      m_sum = m_base + int'(step_up) - int'(step_dn);
      if (m_sum > LIM || m_sum < -LIM) begin
        pend = m_base;
        ovf_q.push_back(cyc);
      end else pend = m_sum;
    end
  end

  // detent monitor: pops an expected detent whenever the lines leave idle
  initial forever begin
    @(negedge clk);
    if (mon_en && {rotary_clk, rotary_dt} != 2'b11) begin
      det_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_detent", cyc, -1);
        m_e = '{cyc, rotary_clk ? 1 : -1};
      end else m_e = exp_q.pop_front();
      check("detent_start", cyc, m_e.start);
      for (int i = 0; i <= DET; i++) begin
        if (i > 0) @(negedge clk);
        check("lines", {rotary_clk, rotary_dt}, i < 4 * P ? lvl(m_e.dir, i / P) : 3);
        check("step_done", step_done, i == 4 * P);
        check("busy", busy, i < DET);
      end
    end else if (mon_en) check("idle_busy", busy, 0);
  end

  initial forever begin
    @(negedge clk);
    if (armed) check("pending", pending, pend);
    if (overflow) begin
      ovf_cnt++;
      if (ovf_q.size() == 0) check("unexpected_overflow", cyc, -1);
      else check("overflow_cycle", cyc, ovf_q.pop_front());
    end
  end

  // loopback decoder: direction is DT's level at CLK's falling edge
  initial forever begin
    @(negedge clk);
    if (prev_clk && !rotary_clk) begin
      if (rotary_dt) dn_seen++; else up_seen++;
    end
    prev_clk = rotary_clk;
  end

  task automatic pulse(input logic u, input logic d);
    step_up = u;
    step_dn = d;
    @(negedge clk);
    step_up = 1'b0;
    step_dn = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(pend == 0 && !busy && exp_q.size() == 0 && cyc >= free_at) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", n, 0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, o0, u0, n0, r, n, sd, bs;
    repeat (2) @(negedge clk);
    check("rst_clk", rotary_clk, 1);
    check("rst_dt", rotary_dt, 1);
    check("rst_busy", busy, 0);
    check("rst_done", step_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pending", pending, 0);
    res_n = 1'b1;
    armed = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    u0 = up_seen; d0 = det_cnt;
    pulse(1'b1, 1'b0);
    check("first_phase_latency", {rotary_clk, rotary_dt}, 3);
    @(negedge clk);
    check("first_phase_up", {rotary_clk, rotary_dt}, 2);
    wait_idle();
    check("single_up_detents", det_cnt - d0, 1);
    check("single_up_decoded", up_seen - u0, 1);

    n0 = dn_seen; d0 = det_cnt;
    pulse(1'b0, 1'b1);
    wait_idle();
    check("single_dn_detents", det_cnt - d0, 1);
    check("single_dn_decoded", dn_seen - n0, 1);

    d0 = det_cnt;
    pulse(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("cancel_pending", pending, 0);
    check("cancel_busy", busy, 0);
    check("cancel_detents", det_cnt - d0, 0);

    d0 = det_cnt; o0 = ovf_cnt;
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("sat_busy", busy, 1);
    repeat (9) pulse(1'b1, 1'b0);
    check("sat_pending", pending, 7);
    wait_idle();
    check("sat_detents", det_cnt - d0, 8);
    check("sat_overflows", ovf_cnt - o0, 2);

    u0 = up_seen; n0 = dn_seen;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    repeat (3) pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    repeat (2) pulse(1'b0, 1'b1);
    check("rev_pending", pending, 1);
    wait_idle();
    check("rev_up", up_seen - u0, 2);
    check("rev_dn", dn_seen - n0, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      pulse(r < 5, r >= 4 && r < 8);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle();
    check("total_up", up_seen, up_exp);
    check("total_dn", dn_seen, dn_exp);
    check("left_detents", exp_q.size(), 0);
    check("left_overflows", ovf_q.size(), 0);

    mon_en = 1'b0;
    u0 = up_seen + dn_seen;
    repeat (3) pulse(1'b1, 1'b0);
    n = 0;
    while ({rotary_clk, rotary_dt} != 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_ph2", n < 100, 1);
    check("pre_rst_pending", pending, 2);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    check("mid_rst_lines", {rotary_clk, rotary_dt}, 3);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_busy", busy, 0);
    sd = 0; bs = 0;
    repeat (40) begin
      @(negedge clk);
      sd += int'(step_done);
      bs += int'(busy);
    end
    check("post_rst_done", sd, 0);
    check("post_rst_busy", bs, 0);
    check("partial_events_le1", (up_seen + dn_seen - u0) <= 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
